// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// default reset PC / increment / drain depth, and drain-counter sizing.
// Optional feature macro used by this slice: PC_SEQ_DELAY_SLOT_EN.
package pc_seq_pkg;

    localparam int STATE_W = 3;

    // Encoding is visible on o_state for the debug unit, so it is fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
    localparam int          DEF_PC_INC       = 4;
    localparam int          DEF_DRAIN_CYCLES = 4;

    // Width of the drain counter; one extra bit keeps DRAIN_CYCLES=1 legal.
    function automatic int drain_ctr_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pc_seq_drain_ctr.sv
// Loadable down-counter used to retire in-flight instructions after HALT.
// Latency: load/decrement visible one cycle later; zero_o is combinational from the count.
// Backpressure: decrements only on en_i, saturates at zero.
module pc_seq_drain_ctr #(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer (continuous / single-step / drain / halt).
// Latency: o_pc is registered (one edge after an enabled cycle); o_pipe_en and o_flush are combinational.
// Backpressure: i_stall holds the PC while enabled; step mode advances one cycle per i_step pulse.
// Optional macro PC_SEQ_DELAY_SLOT_EN: delay-slot architecture, o_flush tied low.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_INC       = DEF_PC_INC,
    parameter int                DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    input  logic               i_stall,
    input  logic               i_halt,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_pipe_en,
    output logic               o_flush,
    output logic               o_halted,
    output logic [STATE_W-1:0] o_state
);

    localparam int CW = drain_ctr_w(DRAIN_CYCLES);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              mode_q;      // 1 = single-step, latched at start
    logic              en;
    logic              flush;
    logic              ctr_load;
    logic              ctr_en;
    logic              ctr_zero;

    // Pipeline enable, next PC and drain-counter controls from state and inputs.
    always_comb begin
        en       = 1'b0;
        flush    = 1'b0;
        ctr_load = 1'b0;
        pc_d     = pc_q;
        unique case (state_q)
            ST_RUN:   en = 1'b1;
            ST_STEP:  en = i_step;
            ST_DRAIN: en = mode_q ? i_step : 1'b1;
            default:  en = 1'b0;
        endcase
        // Redirect outranks stall/halt: those belong to the wrong path.
        if (((state_q == ST_RUN) || (state_q == ST_STEP)) && en) begin
            if (i_redirect) begin
                pc_d = i_redirect_addr;
`ifndef PC_SEQ_DELAY_SLOT_EN
                flush = 1'b1;
`endif
            end else if (i_stall) begin
                pc_d = pc_q;
            end else if (i_halt) begin
                ctr_load = 1'b1;
            end else begin
                pc_d = pc_q + ADDR_W'(PC_INC);
            end
        end
        ctr_en = (state_q == ST_DRAIN) && en;
    end

    // State machine and PC register; reset from any state returns to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            mode_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        mode_q  <= i_step_mode;
                        state_q <= i_step_mode ? ST_STEP : ST_RUN;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (ctr_load) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ctr_en && ctr_zero) begin
                        state_q <= ST_HALTED;
                    end
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    pc_seq_drain_ctr #(
        .CW(CW)
    ) u_drain_ctr (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (ctr_load),
        .load_val_i (CW'(DRAIN_CYCLES - 1)),
        .en_i       (ctr_en),
        .zero_o     (ctr_zero)
    );

    assign o_pc      = pc_q;
    assign o_pipe_en = en;
    assign o_flush   = flush;
    assign o_halted  = (state_q == ST_HALTED);
    assign o_state   = state_q;

endmodule
